// File: rtl/vx_commit_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : vx_commit_tracker_if
// Brief    : Issue/commit notification bundle between pipeline and tracker.
// Revision : 1.0
// ============================================================================
interface vx_commit_tracker_if #(
  parameter int NUM_WARPS   = 8,
  parameter int ISSUE_WIDTH = 2
);
  localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic [ISSUE_WIDTH-1:0]               issue_valid;
  logic [ISSUE_WIDTH-1:0][NW_WIDTH-1:0] issue_wid;
  logic [ISSUE_WIDTH-1:0]               committed;
  logic [ISSUE_WIDTH-1:0][NW_WIDTH-1:0] committed_wid;
  logic [ISSUE_WIDTH-1:0]               true_eop;
  logic [NUM_WARPS-1:0]                 pending_empty;
  logic [NUM_WARPS-1:0]                 warp_done;
  logic                                 busy;
  logic                                 ovf_err;
  logic                                 unf_err;

  modport master (
    output issue_valid, issue_wid, committed, committed_wid, true_eop,
    input  pending_empty, warp_done, busy, ovf_err, unf_err
  );

  modport slave (
    input  issue_valid, issue_wid, committed, committed_wid, true_eop,
    output pending_empty, warp_done, busy, ovf_err, unf_err
  );
endinterface
`default_nettype wire

// File: rtl/vx_commit_tracker.sv
`default_nettype none
// ============================================================================
// Module   : vx_commit_tracker
// Brief    : Per-warp in-flight instruction counters with drain/EOP reporting.
// Revision : 1.0
// ============================================================================
module vx_commit_tracker #(
  parameter int NUM_WARPS   = 8,
  parameter int ISSUE_WIDTH = 2,
  parameter int CTR_WIDTH   = 6
) (
  input  wire                  clk,
  input  wire                  reset,
  vx_commit_tracker_if.slave   bus
);
  localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int c_nxt_w  = CTR_WIDTH + 2;
  localparam logic signed [c_nxt_w-1:0] c_one     = c_nxt_w'(1);
  localparam logic signed [c_nxt_w-1:0] c_zero    = '0;
  localparam logic signed [c_nxt_w-1:0] c_cnt_max = c_nxt_w'((1 << CTR_WIDTH) - 1);

  logic [NUM_WARPS-1:0] w_empty_next;
  logic [NUM_WARPS-1:0] w_ovf_vec;
  logic [NUM_WARPS-1:0] w_unf_vec;
  logic [NUM_WARPS-1:0] w_pending_empty;
  logic [NUM_WARPS-1:0] w_warp_done;
  logic                 r_busy;
  logic                 r_ovf;
  logic                 r_unf;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    logic [CTR_WIDTH-1:0]      r_cnt;
    logic                      r_eop;
    logic                      r_done;
    logic                      r_empty;
    logic signed [c_nxt_w-1:0] w_next;
    logic [CTR_WIDTH-1:0]      w_cnt_next;
    logic                      w_eop_next;
    logic                      w_done_next;
    logic                      w_ovf;
    logic                      w_unf;

    always_comb begin
      w_next     = {2'b00, r_cnt};
      w_eop_next = r_eop;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (bus.issue_valid[i] && (bus.issue_wid[i] == NW_WIDTH'(w)))
          w_next = w_next + c_one;
        if (bus.committed[i] && (bus.committed_wid[i] == NW_WIDTH'(w))) begin
          w_next = w_next - c_one;
          if (bus.true_eop[i])
            w_eop_next = 1'b1;
        end
      end
      w_ovf      = 1'b0;
      w_unf      = 1'b0;
      w_cnt_next = w_next[CTR_WIDTH-1:0];
      if (w_next > c_cnt_max) begin
        w_cnt_next = '1;
        w_ovf      = 1'b1;
      end else if (w_next < c_zero) begin
        w_cnt_next = '0;
        w_unf      = 1'b1;
      end
      // Done is judged on next-state so the pulse lands right after the draining commit.
      w_done_next = w_eop_next && (w_cnt_next == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt   <= '0;
        r_eop   <= 1'b0;
        r_done  <= 1'b0;
        r_empty <= 1'b1;
      end else begin
        r_cnt   <= w_cnt_next;
        r_eop   <= w_eop_next && !w_done_next;
        r_done  <= w_done_next;
        r_empty <= (w_cnt_next == '0);
      end
    end

    assign w_empty_next[w]    = (w_cnt_next == '0);
    assign w_ovf_vec[w]       = w_ovf;
    assign w_unf_vec[w]       = w_unf;
    assign w_pending_empty[w] = r_empty;
    assign w_warp_done[w]     = r_done;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      r_busy <= ~&w_empty_next;
      r_ovf  <= r_ovf | (|w_ovf_vec);
      r_unf  <= r_unf | (|w_unf_vec);
    end
  end

  assign bus.pending_empty = w_pending_empty;
  assign bus.warp_done     = w_warp_done;
  assign bus.busy          = r_busy;
  assign bus.ovf_err       = r_ovf;
  assign bus.unf_err       = r_unf;
endmodule
`default_nettype wire

// File: tb/tb_vx_commit_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_commit_tracker
// Brief    : Table, directed and random checks of vx_commit_tracker.
// Revision : 1.0
// ============================================================================
module tb_vx_commit_tracker;
  localparam int NUM_WARPS   = 8;
  localparam int ISSUE_WIDTH = 2;
  localparam int CTR_WIDTH   = 6;
  localparam int CNT_MAX     = (1 << CTR_WIDTH) - 1;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  vx_commit_tracker_if #(.NUM_WARPS(NUM_WARPS), .ISSUE_WIDTH(ISSUE_WIDTH)) bus ();

  vx_commit_tracker #(
    .NUM_WARPS  (NUM_WARPS),
    .ISSUE_WIDTH(ISSUE_WIDTH),
    .CTR_WIDTH  (CTR_WIDTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference state: plain integer counts and flags per warp.
  int       m_cnt [NUM_WARPS];
  bit       m_eop [NUM_WARPS];
  bit [7:0] m_done;
  bit       m_ovf, m_unf;

  typedef struct {
    logic [1:0] iv;
    logic [5:0] iw;
    logic [1:0] cm;
    logic [5:0] cw;
    logic [1:0] te;
    logic [7:0] pe;
    logic [7:0] done;
    logic       busy;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NUM_WARPS; w++) begin
      m_cnt[w] = 0;
      m_eop[w] = 1'b0;
    end
    m_done = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] iv, input logic [5:0] iw,
                            input logic [1:0] cm, input logic [5:0] cw,
                            input logic [1:0] te);
    for (int w = 0; w < NUM_WARPS; w++) begin
      int n;
      bit e;
      n = m_cnt[w];
      e = m_eop[w];
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (iv[i] && int'(iw[i*3 +: 3]) == w) n = n + 1;
        if (cm[i] && int'(cw[i*3 +: 3]) == w) begin
          n = n - 1;
          if (te[i]) e = 1'b1;
        end
      end
      if (n > CNT_MAX) begin n = CNT_MAX; m_ovf = 1'b1; end
      else if (n < 0) begin n = 0; m_unf = 1'b1; end
      m_cnt[w]  = n;
      m_done[w] = e && (n == 0);
      m_eop[w]  = e && !m_done[w];
    end
  endtask

  function automatic logic [7:0] model_pe();
    logic [7:0] pe;
    for (int w = 0; w < NUM_WARPS; w++) pe[w] = (m_cnt[w] == 0);
    return pe;
  endfunction

  task automatic compare_model(input string tag);
    check({tag, " pending_empty"}, 32'(bus.pending_empty), 32'(model_pe()));
    check({tag, " warp_done"},     32'(bus.warp_done),     32'(m_done));
    check({tag, " busy"},          32'(bus.busy),          32'(model_pe() != 8'hFF));
    check({tag, " ovf_err"},       32'(bus.ovf_err),       32'(m_ovf));
    check({tag, " unf_err"},       32'(bus.unf_err),       32'(m_unf));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic drive(input string tag, input logic [1:0] iv, input logic [5:0] iw,
                       input logic [1:0] cm, input logic [5:0] cw, input logic [1:0] te);
    bus.issue_valid   = iv;
    bus.issue_wid     = iw;
    bus.committed     = cm;
    bus.committed_wid = cw;
    bus.true_eop      = te;
    model_step(iv, iw, cm, cw, te);
    @(posedge clk);
    #1;
    compare_model(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    drive(tag, 2'b00, 6'o00, 2'b00, 6'o00, 2'b00);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " pending_empty"}, 32'(bus.pending_empty), 32'hFF);
    check({tag, " warp_done"},     32'(bus.warp_done),     32'h00);
    check({tag, " busy"},          32'(bus.busy),          32'h0);
    check({tag, " ovf_err"},       32'(bus.ovf_err),       32'h0);
    check({tag, " unf_err"},       32'(bus.unf_err),       32'h0);
  endtask

  initial begin
    tbl[0]  = '{iv:2'b11, iw:6'o22, cm:2'b00, cw:6'o00, te:2'b00, pe:8'hFB, done:8'h00, busy:1'b1};
    tbl[1]  = '{iv:2'b01, iw:6'o02, cm:2'b00, cw:6'o00, te:2'b00, pe:8'hFB, done:8'h00, busy:1'b1};
    tbl[2]  = '{iv:2'b00, iw:6'o00, cm:2'b11, cw:6'o22, te:2'b00, pe:8'hFB, done:8'h00, busy:1'b1};
    tbl[3]  = '{iv:2'b00, iw:6'o00, cm:2'b10, cw:6'o20, te:2'b00, pe:8'hFF, done:8'h00, busy:1'b0};
    tbl[4]  = '{iv:2'b00, iw:6'o00, cm:2'b00, cw:6'o00, te:2'b00, pe:8'hFF, done:8'h00, busy:1'b0};
    tbl[5]  = '{iv:2'b01, iw:6'o05, cm:2'b00, cw:6'o00, te:2'b00, pe:8'hDF, done:8'h00, busy:1'b1};
    tbl[6]  = '{iv:2'b11, iw:6'o55, cm:2'b11, cw:6'o55, te:2'b00, pe:8'hDF, done:8'h00, busy:1'b1};
    tbl[7]  = '{iv:2'b00, iw:6'o00, cm:2'b01, cw:6'o05, te:2'b01, pe:8'hFF, done:8'h20, busy:1'b0};
    tbl[8]  = '{iv:2'b00, iw:6'o00, cm:2'b00, cw:6'o00, te:2'b00, pe:8'hFF, done:8'h00, busy:1'b0};
    tbl[9]  = '{iv:2'b00, iw:6'o00, cm:2'b00, cw:6'o01, te:2'b01, pe:8'hFF, done:8'h00, busy:1'b0};
    tbl[10] = '{iv:2'b01, iw:6'o01, cm:2'b01, cw:6'o01, te:2'b00, pe:8'hFF, done:8'h00, busy:1'b0};

    bus.issue_valid   = '0;
    bus.issue_wid     = '0;
    bus.committed     = '0;
    bus.committed_wid = '0;
    bus.true_eop      = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    // Table vectors: hand-derived expectations plus the model in lockstep.
    for (int k = 0; k < 11; k++) begin
      drive($sformatf("tbl%0d", k), tbl[k].iv, tbl[k].iw, tbl[k].cm, tbl[k].cw, tbl[k].te);
      check($sformatf("tbl%0d pe", k),   32'(bus.pending_empty), 32'(tbl[k].pe));
      check($sformatf("tbl%0d done", k), 32'(bus.warp_done),     32'(tbl[k].done));
      check($sformatf("tbl%0d busy", k), 32'(bus.busy),          32'(tbl[k].busy));
    end

    // EOP arrives while one instruction is still outstanding on warp 1.
    drive("eop_iss", 2'b11, 6'o11, 2'b00, 6'o00, 2'b00);
    drive("eop_first", 2'b00, 6'o00, 2'b01, 6'o01, 2'b01);
    check("eop_early done", 32'(bus.warp_done), 32'h00);
    drive("eop_last", 2'b00, 6'o00, 2'b10, 6'o10, 2'b00);
    check("eop_n1 done", 32'(bus.warp_done), 32'h02);
    idle("eop_after");
    check("eop_n2 done", 32'(bus.warp_done), 32'h00);

    // Fill warp 4 to the limit, then push past it.
    for (int k = 0; k < 31; k++) drive("fill", 2'b11, 6'o44, 2'b00, 6'o00, 2'b00);
    drive("fill_last", 2'b01, 6'o04, 2'b00, 6'o00, 2'b00);
    check("at_max ovf", 32'(bus.ovf_err), 32'h0);
    drive("ovf", 2'b11, 6'o44, 2'b00, 6'o00, 2'b00);
    check("ovf set", 32'(bus.ovf_err), 32'h1);
    check("ovf pe4", 32'(bus.pending_empty[4]), 32'h0);
    idle("ovf_hold");
    check("ovf sticky", 32'(bus.ovf_err), 32'h1);
    drive("unf", 2'b00, 6'o00, 2'b01, 6'o06, 2'b00);
    check("unf set", 32'(bus.unf_err), 32'h1);
    check("unf pe6", 32'(bus.pending_empty[6]), 32'h1);
    for (int k = 0; k < 31; k++) drive("drain", 2'b00, 6'o00, 2'b11, 6'o44, 2'b00);
    drive("drain_last", 2'b00, 6'o00, 2'b01, 6'o04, 2'b00);
    check("drained pe", 32'(bus.pending_empty), 32'hFF);
    check("drained ovf", 32'(bus.ovf_err), 32'h1);

    // Asynchronous reset while warps 0 and 3 hold EOP flags with work pending.
    drive("rst_iss0", 2'b11, 6'o30, 2'b00, 6'o00, 2'b00);
    drive("rst_iss1", 2'b11, 6'o30, 2'b00, 6'o00, 2'b00);
    drive("rst_eop", 2'b00, 6'o00, 2'b11, 6'o30, 2'b11);
    bus.issue_valid = 2'b01;
    bus.issue_wid   = 6'o02;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_values("async_rst");
    bus.issue_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    drive("post_rst_w0", 2'b01, 6'o00, 2'b01, 6'o00, 2'b00);
    drive("post_rst_w3", 2'b01, 6'o03, 2'b01, 6'o03, 2'b00);
    check("post_rst done", 32'(bus.warp_done), 32'h00);
    for (int k = 0; k < 3; k++) idle("post_rst_idle");

    // Random traffic; commits mostly target warps with outstanding work.
    for (int k = 0; k < 600; k++) begin
      logic [1:0] iv, cm, te;
      logic [5:0] iw, cw;
      int         used [NUM_WARPS];
      for (int w = 0; w < NUM_WARPS; w++) used[w] = 0;
      iv = 2'($urandom);
      iw = 6'($urandom);
      cw = 6'($urandom);
      cm = '0;
      te = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        int wid;
        wid = int'(cw[i*3 +: 3]);
        if ((m_cnt[wid] - used[wid] > 0 && $urandom_range(0, 3) != 0) || $urandom_range(0, 63) == 0) begin
          cm[i] = 1'b1;
          used[wid]++;
        end
        te[i] = ($urandom_range(0, 7) == 0);
      end
      drive("rand", iv, iw, cm, cw, te);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
